// File: rtl/kgp_pkg.sv
// KGPminiRISC shared definitions: datapath widths, execute function codes
// and the lowest-differing-bit helper.
package kgp_pkg;

  localparam int DATA_W = 32;
  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FUNC_ADD   = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_COMP  = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_AND   = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_XOR   = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_SHLL  = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_SHRL  = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_SHRA  = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_SHLLV = 4'd7;
  localparam logic [FUNC_W-1:0] FUNC_SHRLV = 4'd8;
  localparam logic [FUNC_W-1:0] FUNC_SHRAV = 4'd9;
  localparam logic [FUNC_W-1:0] FUNC_DIFF  = 4'd10;
  localparam logic [FUNC_W-1:0] FUNC_MOVB  = 4'd11;

  localparam logic [5:0] DIFF_NONE = 6'd32;

  // Scan from the top so the last hit is the lowest set bit.
  function automatic logic [5:0] lowest_set(input logic [DATA_W-1:0] v);
    logic [5:0] idx;
    idx = DIFF_NONE;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the execute stage: result, carry update
// and illegal-code detection.
module alu_core
  import kgp_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              carry_wr,
  output logic              illegal
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    carry_wr  = 1'b0;
    illegal   = 1'b0;
    unique case (func)
      FUNC_ADD: begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
        carry_wr  = 1'b1;
      end
      FUNC_COMP: begin
        result    = ~b + 1'b1;
        carry_out = (b == '0);
        carry_wr  = 1'b1;
      end
      FUNC_AND:   result = a & b;
      FUNC_XOR:   result = a ^ b;
      FUNC_SHLL:  result = a << shamt;
      FUNC_SHRL:  result = a >> shamt;
      FUNC_SHRA:  result = $unsigned($signed(a) >>> shamt);
      FUNC_SHLLV: result = a << b[4:0];
      FUNC_SHRLV: result = a >> b[4:0];
      FUNC_SHRAV: result = $unsigned($signed(a) >>> b[4:0]);
      FUNC_DIFF:  result = {{(DATA_W-6){1'b0}}, lowest_set(a ^ b)};
      FUNC_MOVB:  result = b;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// KGPminiRISC execute stage: handshake, 1-entry result register
// and the carry/zero/sign flags consumed by the branch unit.
module exec_stage
  import kgp_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int FUNC_W_P = FUNC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FUNC_W_P-1:0] in_func,
  input  logic [DATA_W_P-1:0] in_a,
  input  logic [DATA_W_P-1:0] in_b,
  input  logic [4:0]          in_shamt,
  input  logic [4:0]          in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W_P-1:0] out_result,
  output logic [4:0]          out_rd,
  output logic                out_we,
  output logic                out_illegal,
  output logic                flag_carry,
  output logic                flag_zero,
  output logic                flag_sign
);

  logic [DATA_W_P-1:0] alu_result;
  logic                alu_carry;
  logic                alu_carry_wr;
  logic                alu_illegal;
  logic                accept;

  alu_core u_alu (
    .func      (in_func),
    .a         (in_a),
    .b         (in_b),
    .shamt     (in_shamt),
    .result    (alu_result),
    .carry_out (alu_carry),
    .carry_wr  (alu_carry_wr),
    .illegal   (alu_illegal)
  );

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
      flag_carry  <= 1'b0;
      flag_zero   <= 1'b0;
      flag_sign   <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_rd      <= in_rd;
      out_we      <= !alu_illegal;
      out_illegal <= alu_illegal;
      if (!alu_illegal) begin
        flag_zero <= (alu_result == '0);
        flag_sign <= alu_result[DATA_W_P-1];
      end
      if (alu_carry_wr) flag_carry <= alu_carry;
    end else if (flush || out_ready) begin
      // Consumed or redirected: drop valid, keep the data registers.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed vector table, handshake
// corner sequences and randomized traffic against a behavioural model.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_func;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_shamt, in_rd, out_rd;
  logic        out_we, out_illegal, flag_carry, flag_zero, flag_sign;

  int checks = 0;
  int errors = 0;

  bit        m_valid, m_we, m_ill, m_c, m_z, m_s;
  bit [31:0] m_res;
  bit [4:0]  m_rd;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_a(in_a), .in_b(in_b),
    .in_shamt(in_shamt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_we(out_we), .out_illegal(out_illegal),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .flag_sign(flag_sign)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the operation definitions, using 64-bit arithmetic.
  function automatic void ref_alu(input bit [3:0] f, input bit [31:0] a,
                                  input bit [31:0] b, input bit [4:0] sh,
                                  output bit [31:0] r, output bit cw,
                                  output bit c, output bit ill);
    longint m, ua, ub, sa, p, t;
    int s;
    m = 64'h1_0000_0000;
    ua = a;
    ub = b;
    sa = $signed(a);
    r = 0; cw = 0; c = 0; ill = 0;
    s = (f == 4 || f == 5 || f == 6) ? int'(sh) : int'(b % 32);
    p = longint'(1) << s;
    case (f)
      0: begin t = ua + ub; r = t[31:0]; cw = 1; c = (t >= m); end
      1: begin t = (m - ub) % m; r = t[31:0]; cw = 1; c = (b == 0); end
      2: r = a & b;
      3: r = a ^ b;
      4, 7: begin t = (ua * p) % m; r = t[31:0]; end
      5, 8: begin t = ua / p; r = t[31:0]; end
      6, 9: begin
        t = (sa < 0) ? (sa - (p - 1)) / p : sa / p;
        r = t[31:0];
      end
      10: begin
        r = 32;
        for (int i = 31; i >= 0; i--) if (a[i] != b[i]) r = i;
      end
      11: r = b;
      default: ill = 1;
    endcase
  endfunction

  task automatic cycle(input bit r, input bit fl, input bit iv,
                       input bit ordy, input bit [3:0] f,
                       input bit [31:0] a, input bit [31:0] b,
                       input bit [4:0] sh, input bit [4:0] rd);
    bit rdy, acc, cw, c, ill;
    bit [31:0] res;
    rst = r; flush = fl; in_valid = iv; out_ready = ordy;
    in_func = f; in_a = a; in_b = b; in_shamt = sh; in_rd = rd;
    #1;
    rdy = !fl && (!m_valid || ordy);
    if (!r) chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    acc = iv && rdy;
    ref_alu(f, a, b, sh, res, cw, c, ill);
    @(posedge clk);
    #1;
    if (r) begin
      {m_valid, m_we, m_ill, m_c, m_z, m_s} = '0;
      m_res = 0; m_rd = 0;
    end else if (acc) begin
      m_valid = 1; m_res = res; m_rd = rd; m_we = !ill; m_ill = ill;
      if (!ill) begin m_z = (res == 0); m_s = res[31]; end
      if (cw) m_c = c;
    end else if (fl || (m_valid && ordy)) begin
      m_valid = 0;
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_result", out_result, m_res);
    chk("out_rd", {27'b0, out_rd}, {27'b0, m_rd});
    chk("we_ill", {30'b0, out_we, out_illegal}, {30'b0, m_we, m_ill});
    chk("flags", {29'b0, flag_carry, flag_zero, flag_sign},
        {29'b0, m_c, m_z, m_s});
    @(negedge clk);
  endtask

  typedef struct {
    bit [3:0]  f;
    bit [31:0] a, b;
    bit [4:0]  sh;
    bit [31:0] res;
    bit        we, ill, c, z, s;
  } vec_t;

  vec_t tbl[12];
  bit [3:0] rf;
  bit [31:0] ra, rb;

  initial begin
    tbl[0]  = '{0,  32'hFFFFFFFF, 32'h1,        0, 32'h0,        1, 0, 1, 1, 0};
    tbl[1]  = '{10, 32'h10,       32'h30,       0, 32'd5,        1, 0, 1, 0, 0};
    tbl[2]  = '{10, 32'h1234ABCD, 32'h1234ABCD, 0, 32'h20,       1, 0, 1, 0, 0};
    tbl[3]  = '{6,  32'h80000000, 32'h0,        4, 32'hF8000000, 1, 0, 1, 0, 1};
    tbl[4]  = '{1,  32'h0,        32'h1,        0, 32'hFFFFFFFF, 1, 0, 0, 0, 1};
    tbl[5]  = '{14, 32'h5,        32'h7,        0, 32'h0,        0, 1, 0, 0, 1};
    tbl[6]  = '{0,  32'h1,        32'h2,        0, 32'h3,        1, 0, 0, 0, 0};
    tbl[7]  = '{1,  32'h9,        32'h0,        0, 32'h0,        1, 0, 1, 1, 0};
    tbl[8]  = '{7,  32'h1,        32'h3F,       0, 32'h80000000, 1, 0, 1, 0, 1};
    tbl[9]  = '{5,  32'hF0000000, 32'h0,        0, 32'hF0000000, 1, 0, 1, 0, 1};
    tbl[10] = '{3,  32'hFF,       32'hFF,       0, 32'h0,        1, 0, 1, 1, 0};
    tbl[11] = '{11, 32'h0,        32'h80000001, 0, 32'h80000001, 1, 0, 1, 0, 1};

    cycle(1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_ready", {31'b0, in_ready}, 32'h1);

    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 1, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].sh, 5'(i));
      chk("tbl_result", out_result, tbl[i].res);
      chk("tbl_ctrl", {29'b0, out_valid, out_we, out_illegal},
          {29'b0, 1'b1, tbl[i].we, tbl[i].ill});
      chk("tbl_flags", {29'b0, flag_carry, flag_zero, flag_sign},
          {29'b0, tbl[i].c, tbl[i].z, tbl[i].s});
    end

    // Stall: op A lands, then op B is held for three blocked cycles.
    cycle(0, 0, 1, 1, 0, 32'h7, 32'h8, 0, 5'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 3, 32'hAAAA0000, 32'h0000BBBB, 0, 5'd2);
      chk("stall_hold", out_result, 32'hF);
    end
    cycle(0, 0, 1, 1, 3, 32'hAAAA0000, 32'h0000BBBB, 0, 5'd2);
    chk("stall_release", out_result, 32'hAAAABBBB);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("drain", {31'b0, out_valid}, 32'h0);

    // Flush while holding a result, with upstream still offering an op.
    cycle(0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'h2, 0, 5'd3);
    cycle(0, 1, 1, 0, 11, 0, 32'h0, 0, 5'd4);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_flags", {29'b0, flag_carry, flag_zero, flag_sign}, 32'h4);

    // Reset during a stall with carry set.
    cycle(0, 0, 1, 1, 0, 32'hFFFFFFFF, 32'h3, 0, 5'd5);
    cycle(0, 0, 1, 0, 0, 32'h1, 32'h1, 0, 5'd6);
    chk("pre_rst_carry", {31'b0, flag_carry}, 32'h1);
    cycle(1, 0, 1, 0, 0, 32'h1, 32'h1, 0, 5'd6);
    chk("rst_state", {27'b0, out_valid, out_we, flag_carry, flag_zero,
        flag_sign}, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", {31'b0, in_ready}, 32'h1);

    for (int i = 0; i < 400; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'h0;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            rf, ra, rb, 5'($urandom), 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
